// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between an instruction-fetch port and a
//   data port. Only one transaction is in flight at a time:
//   IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> RESP -> IDLE.
//   When both ports request in the same IDLE cycle, the port that was not
//   granted last wins. Every output is driven straight from a flop.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req/if_addr              fetch request and address
//   if_gnt/if_rvalid/if_rdata   fetch grant pulse, response pulse, read data
//   d_req/d_we/d_addr/d_wdata   data request, write flag, address, write data
//   d_gnt/d_rvalid/d_rdata      data grant pulse, completion pulse, read data
//   mem_en/mem_we/mem_addr/mem_wdata  memory command (ACCESS cycle only)
//   mem_rdata                   memory read data, valid MEM_LAT cycles after mem_en
//   busy                        high whenever the arbiter is not IDLE
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [2:0] LAT_CNT = 3'(MEM_LAT);

  state_t            state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic              last_gnt_d_reg, last_gnt_d_next;  // 1: data port was granted last
  logic              sel_d_reg, sel_d_next;            // transaction belongs to data port
  logic              wr_reg, wr_next;                  // transaction is a data write
  logic              if_gnt_reg, if_gnt_next;
  logic              d_gnt_reg, d_gnt_next;
  logic              if_rvalid_reg, if_rvalid_next;
  logic              d_rvalid_reg, d_rvalid_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;
  logic              mem_en_reg, mem_en_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic              busy_reg, busy_next;
  logic              grant_d;

  // Data wins when it is the only requester, or on a conflict when fetch
  // was granted last.
  assign grant_d = d_req && (!if_req || !last_gnt_d_reg);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    last_gnt_d_next = last_gnt_d_reg;
    sel_d_next      = sel_d_reg;
    wr_next         = wr_reg;
    if_gnt_next     = 1'b0;
    d_gnt_next      = 1'b0;
    if_rvalid_next  = 1'b0;
    d_rvalid_next   = 1'b0;
    if_rdata_next   = if_rdata_reg;
    d_rdata_next    = d_rdata_reg;
    mem_en_next     = 1'b0;
    mem_we_next     = 1'b0;
    mem_addr_next   = '0;
    mem_wdata_next  = '0;

    case (state_reg)
      IDLE: begin
        // The ACCESS-cycle outputs are loaded here so they appear registered
        // in the very cycle the state becomes ACCESS.
        if (if_req || d_req) begin
          state_next      = ACCESS;
          last_gnt_d_next = grant_d;
          sel_d_next      = grant_d;
          wr_next         = grant_d && d_we;
          if_gnt_next     = !grant_d;
          d_gnt_next      = grant_d;
          mem_en_next     = 1'b1;
          mem_we_next     = grant_d && d_we;
          mem_addr_next   = grant_d ? d_addr : if_addr;
          mem_wdata_next  = grant_d ? d_wdata : '0;
        end
      end
      ACCESS: begin
        state_next = WAIT;
        cnt_next   = 3'd1;
      end
      WAIT: begin
        if (cnt_reg == LAT_CNT) begin
          // Last WAIT cycle: memory data is valid now; latch it together
          // with the response pulse for the RESP cycle.
          state_next     = RESP;
          cnt_next       = 3'd0;
          if_rvalid_next = !sel_d_reg;
          d_rvalid_next  = sel_d_reg;
          if (!sel_d_reg) begin
            if_rdata_next = mem_rdata;
          end else if (!wr_reg) begin
            d_rdata_next = mem_rdata;
          end
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= 3'd0;
      last_gnt_d_reg <= 1'b0;
      sel_d_reg      <= 1'b0;
      wr_reg         <= 1'b0;
      if_gnt_reg     <= 1'b0;
      d_gnt_reg      <= 1'b0;
      if_rvalid_reg  <= 1'b0;
      d_rvalid_reg   <= 1'b0;
      if_rdata_reg   <= '0;
      d_rdata_reg    <= '0;
      mem_en_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      last_gnt_d_reg <= last_gnt_d_next;
      sel_d_reg      <= sel_d_next;
      wr_reg         <= wr_next;
      if_gnt_reg     <= if_gnt_next;
      d_gnt_reg      <= d_gnt_next;
      if_rvalid_reg  <= if_rvalid_next;
      d_rvalid_reg   <= d_rvalid_next;
      if_rdata_reg   <= if_rdata_next;
      d_rdata_reg    <= d_rdata_next;
      mem_en_reg     <= mem_en_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      busy_reg       <= busy_next;
    end
  end

  assign if_gnt    = if_gnt_reg;
  assign d_gnt     = d_gnt_reg;
  assign if_rvalid = if_rvalid_reg;
  assign d_rvalid  = d_rvalid_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with MEM_LAT=2. A table of single
//   transactions is replayed first, followed by hand-written sequences for
//   reset mid-transaction, continuous conflicting requests and streaming
//   fetches. The memory model returns {16'hC0DE, addr}, except address
//   0x0004 which holds 0xDEADBEEF.
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam int AW  = 16;
  localparam int DW  = 32;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.MEM_LAT(LAT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data appears exactly LAT cycles after the mem_en
  // cycle; any other cycle shows a poison value.
  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == 16'h0004) return 32'hDEADBEEF;
    return {16'hC0DE, a};
  endfunction

  logic [DW-1:0] pipe [1:LAT];
  initial for (int k = 1; k <= LAT; k++) pipe[k] = 32'hBAD0BAD0;
  always @(posedge clk) begin
    pipe[1] <= (mem_en && !mem_we) ? mem_val(mem_addr) : 32'hBAD0BAD0;
    for (int k = 2; k <= LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_rdata = pipe[LAT];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Protocol invariants checked every cycle out of reset.
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en <= 1'b0;
    end else begin
      checks++;
      if ((if_gnt && d_gnt) || (if_rvalid && d_rvalid) || (mem_en && prev_en)) begin
        errors++;
        $display("FAIL invariant: gnt=%b%b rvalid=%b%b mem_en=%b prev_en=%b",
                 if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, prev_en);
      end
      prev_en <= mem_en;
    end
  end

  function automatic logic [127:0] all_outs();
    return {9'd0, if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
            mem_en, mem_we, mem_addr, mem_wdata, busy};
  endfunction

  typedef struct {
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          exp_d;        // 1: data port expected to win
    logic [DW-1:0] exp_if_rdata; // if_rdata expected at the response
    logic [DW-1:0] exp_d_rdata;  // d_rdata expected at the response
  } vec_t;

  vec_t vecs [9];

  task automatic drop_reqs();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  // Runs one transaction from request to the IDLE cycle after the response.
  task automatic run_vec(input vec_t v, input string tag);
    bit found;
    int n;
    @(negedge clk);
    if_req = v.if_req; if_addr = v.if_addr;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin found = 1; break; end
    end
    if (!found) begin
      chk({tag, " gnt_timeout"}, 0, 1);
      drop_reqs();
      return;
    end
    chk({tag, " gnt"}, {if_gnt, d_gnt}, {!v.exp_d, v.exp_d});
    chk({tag, " mem_cmd"}, {mem_en, mem_we, mem_addr, mem_wdata},
        {1'b1, v.exp_d & v.d_we, v.exp_d ? v.d_addr : v.if_addr,
         v.exp_d ? v.d_wdata : 32'h0});
    drop_reqs();
    n = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (if_rvalid || d_rvalid) begin n = c; break; end
    end
    chk({tag, " rvalid_delay"}, n, LAT + 1);
    chk({tag, " rvalid_port"}, {if_rvalid, d_rvalid}, {!v.exp_d, v.exp_d});
    chk({tag, " if_rdata"}, if_rdata, v.exp_if_rdata);
    chk({tag, " d_rdata"}, d_rdata, v.exp_d_rdata);
    @(negedge clk);
    chk({tag, " idle_after"}, {busy, if_rvalid, d_rvalid}, 3'b000);
    $display("txn %s: port=%s addr=%h if_rdata=%h d_rdata=%h", tag,
             v.exp_d ? (v.d_we ? "data-wr" : "data-rd") : "fetch",
             v.exp_d ? v.d_addr : v.if_addr, if_rdata, d_rdata);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", all_outs(), 128'd0);
    drop_reqs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : main
    int   gcyc [3];
    logic gport [3];
    int   ng, cyc, nrv, low_cnt, ngnt;
    bit   saw_rv;
    logic [AW-1:0] q_addr [$];
    logic [AW-1:0] a;
    vec_t va;

    //            if_req if_addr  d_req d_we d_addr    d_wdata       exp_d if_rdata       d_rdata
    vecs[0] = '{1'b1, 16'h0004, 1'b0, 1'b0, 16'h0000, 32'h00000000, 1'b0, 32'hDEADBEEF, 32'h00000000};
    vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 32'h12345678, 1'b1, 32'hDEADBEEF, 32'h00000000};
    vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 32'h00000000, 1'b1, 32'hDEADBEEF, 32'hC0DE0020};
    vecs[3] = '{1'b1, 16'h0030, 1'b1, 1'b0, 16'h0040, 32'h00000000, 1'b0, 32'hC0DE0030, 32'hC0DE0020};
    vecs[4] = '{1'b1, 16'h0050, 1'b1, 1'b1, 16'h0060, 32'hCAFEF00D, 1'b1, 32'hC0DE0030, 32'hC0DE0020};
    vecs[5] = '{1'b1, 16'h0070, 1'b1, 1'b0, 16'h0080, 32'h00000000, 1'b0, 32'hC0DE0070, 32'hC0DE0020};
    vecs[6] = '{1'b1, 16'h00A0, 1'b0, 1'b0, 16'h0000, 32'h00000000, 1'b0, 32'hC0DE00A0, 32'hC0DE0020};
    vecs[7] = '{1'b1, 16'h00B0, 1'b1, 1'b0, 16'h00C0, 32'h00000000, 1'b1, 32'hC0DE00A0, 32'hC0DE00C0};
    vecs[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h00D0, 32'h00000000, 1'b1, 32'hC0DE00A0, 32'hC0DE00D0};

    rst_n = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset asserted mid-cycle before the first clock edge.
    #2 rst_n = 1'b0;
    #1 chk("reset_initial", all_outs(), 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset during WAIT of a data read: no response, data wins next conflict.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h00E0;
    ng = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (d_gnt) begin ng = 1; break; end
    end
    chk("rstwait gnt_seen", ng, 1);
    drop_reqs();
    @(negedge clk);
    chk("rstwait busy_in_wait", {busy, mem_en}, 2'b10);
    #2 rst_n = 1'b0;
    #1 chk("rstwait outputs_zero", all_outs(), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_rv = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (if_rvalid || d_rvalid) saw_rv = 1;
    end
    chk("rstwait no_rvalid", saw_rv, 1'b0);
    $display("txn rstwait: reset during WAIT, rvalid_seen=%0d", saw_rv);
    va = '{1'b1, 16'h00F0, 1'b1, 1'b0, 16'h0100, 32'h0, 1'b1, 32'h0, 32'hC0DE0100};
    run_vec(va, "post_reset_conflict");

    // Both requests held continuously after reset: data, fetch, data, 5 apart.
    do_reset();
    if_req = 1'b1; if_addr = 16'h0300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0400;
    ng = 0; cyc = 0;
    while (ng < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (if_gnt || d_gnt) begin
        gcyc[ng] = cyc; gport[ng] = d_gnt; ng++;
      end
    end
    drop_reqs();
    chk("cont grants_seen", ng, 3);
    if (ng == 3) begin
      chk("cont order", {gport[0], gport[1], gport[2]}, 3'b101);
      chk("cont spacing01", gcyc[1] - gcyc[0], LAT + 3);
      chk("cont spacing12", gcyc[2] - gcyc[1], LAT + 3);
      $display("txn cont: grants at %0d/%0d/%0d ports d=%b%b%b",
               gcyc[0], gcyc[1], gcyc[2], gport[0], gport[1], gport[2]);
    end
    repeat (8) @(negedge clk);

    // Streaming fetches with a new address after every grant.
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0200;
    nrv = 0; ngnt = 0; low_cnt = 0;
    for (int c = 0; c < 60 && nrv < 3; c++) begin
      @(negedge clk);
      if (!busy) low_cnt++;
      if (if_gnt) begin
        if (ngnt > 0) chk($sformatf("stream idle_gap%0d", ngnt), low_cnt, 1);
        chk($sformatf("stream busy_in_access%0d", ngnt), busy, 1'b1);
        q_addr.push_back(if_addr);
        if_addr = if_addr + 16'h0010;
        ngnt++;
        low_cnt = 0;
      end
      if (if_rvalid) begin
        a = (q_addr.size() > 0) ? q_addr.pop_front() : 16'hFFFF;
        chk($sformatf("stream rdata%0d", nrv), if_rdata, {16'hC0DE, a});
        $display("txn stream%0d: addr=%h if_rdata=%h", nrv, a, if_rdata);
        nrv++;
      end
    end
    chk("stream responses", nrv, 3);
    drop_reqs();
    repeat (8) @(negedge clk);
    chk("final_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
